// File: rtl/axi_lite_reg_slave_if.sv
// AXI-lite channel bundle with word addressing: write address, write data,
// write response, read address and read data.
interface axi_lite_if #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wavalid;
    logic                  waready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic                  wresp;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  waddr, wavalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output waready, wready, bvalid, wresp, arready, rdata, rvalid
    );

    modport master (
        output waddr, wavalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  waready, wready, bvalid, wresp, arready, rdata, rvalid
    );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// Word-addressed AXI-lite register bank: RW slots drive ctrl_o, RO slots read status_i.
// Independent write (address/data in any order) and read FSMs, one-cycle latency each.
module axi_lite_reg_slave #(
    parameter int               DEPTH      = 32,
    parameter int               DATA_WIDTH = 32,
    parameter logic [DEPTH-1:0] RO_MASK    = {DEPTH{1'b0}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    axi_lite_if.slave                   s_axi,
    output logic [DEPTH*DATA_WIDTH-1:0] ctrl_o,
    output logic [DEPTH-1:0]            wr_pulse_o,
    input  logic [DEPTH*DATA_WIDTH-1:0] status_i
);
    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_DATA } rstate_e;

    wstate_e                          wstate_q;
    rstate_e                          rstate_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] ctrl_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] status_w;
    logic [DEPTH-1:0]                 wr_pulse_q;
    logic                             waready_q, wready_q, bvalid_q, wresp_q;
    logic                             aw_have_q, w_have_q;
    logic [ADDR_WIDTH-1:0]            waddr_q;
    logic [DATA_WIDTH-1:0]            wdata_q;
    logic                             arready_q, rvalid_q;
    logic [DATA_WIDTH-1:0]            rdata_q;

    logic                  aw_fire, w_fire, ar_fire, commit, wr_ok;
    logic                  aw_have_d, w_have_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0] wdata_d, rdata_d;

    assign status_w = status_i;

    // Merge freshly arriving beats with held ones so a same-edge pair commits at once.
    always_comb begin
        aw_fire   = s_axi.wavalid && waready_q;
        w_fire    = s_axi.wvalid && wready_q;
        ar_fire   = s_axi.arvalid && arready_q;
        aw_have_d = aw_have_q || aw_fire;
        w_have_d  = w_have_q || w_fire;
        waddr_d   = aw_fire ? s_axi.waddr : waddr_q;
        wdata_d   = w_fire ? s_axi.wdata : wdata_q;
        commit    = (wstate_q == W_IDLE) && aw_have_d && w_have_d;
        wr_ok     = (int'(waddr_d) < DEPTH) && !RO_MASK[waddr_d];
        rdata_d   = '0;
        if (int'(s_axi.araddr) < DEPTH)
            rdata_d = RO_MASK[s_axi.araddr] ? status_w[s_axi.araddr] : ctrl_q[s_axi.araddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate_q   <= W_IDLE;
            ctrl_q     <= '0;
            wr_pulse_q <= '0;
            waready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            wresp_q    <= 1'b0;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            wr_pulse_q <= '0;
            case (wstate_q)
                W_IDLE: begin
                    if (commit) begin
                        if (wr_ok) begin
                            ctrl_q[waddr_d]     <= wdata_d;
                            wr_pulse_q[waddr_d] <= 1'b1;
                        end
                        wresp_q   <= !wr_ok;
                        bvalid_q  <= 1'b1;
                        waready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_have_q <= 1'b0;
                        w_have_q  <= 1'b0;
                        wstate_q  <= W_RESP;
                    end else begin
                        aw_have_q <= aw_have_d;
                        w_have_q  <= w_have_d;
                        waddr_q   <= waddr_d;
                        wdata_q   <= wdata_d;
                        waready_q <= !aw_have_d;
                        wready_q  <= !w_have_d;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        waready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
            endcase
        end
    end

    // Reads sample ctrl_q before any same-edge commit lands, returning the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        rdata_q   <= rdata_d;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign s_axi.waready = waready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.wresp   = wresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign ctrl_o        = ctrl_q;
    assign wr_pulse_o    = wr_pulse_q;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: vector table of single transactions plus
// hand sequences for out-of-order beats, back-pressure, read/write collision and reset.
module tb_axi_lite_reg_slave;
    localparam int DEPTH = 20;
    localparam int DW    = 32;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [DEPTH-1:0][DW-1:0]    status;
    logic [DEPTH*DW-1:0]         ctrl_o;
    logic [DEPTH-1:0]            wr_pulse_o;
    logic [DEPTH-1:0][DW-1:0]    shadow;
    logic [DEPTH-1:0][DW-1:0]    ctrl_view;
    int                          total = 0;
    int                          passed = 0;

    always #5 clk = ~clk;

    axi_lite_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    axi_lite_reg_slave #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .RO_MASK(20'h00080)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_axi      (bus),
        .ctrl_o     (ctrl_o),
        .wr_pulse_o (wr_pulse_o),
        .status_i   (status)
    );

    assign ctrl_view = ctrl_o;

    typedef struct {
        bit          is_rd;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        exp_resp;
        logic [19:0] exp_pulse;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_ctrl(input string nm);
        total++;
        if (ctrl_o === shadow) passed++;
        else $display("FAIL %s: got %h expected %h", nm, ctrl_o, shadow);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, output logic bv,
                            output logic resp, output logic [19:0] pulse,
                            output logic [19:0] pulse_after, output logic bv_after,
                            output logic tmo);
        logic got_a, got_w, fa, fw;
        bus.waddr = a; bus.wdata = d; bus.wavalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        got_a = 1'b0; got_w = 1'b0;
        for (int n = 0; n < 20 && !(got_a && got_w); n++) begin
            fa = bus.wavalid && bus.waready;
            fw = bus.wvalid && bus.wready;
            tick();
            if (fa) begin got_a = 1'b1; bus.wavalid = 1'b0; end
            if (fw) begin got_w = 1'b1; bus.wvalid = 1'b0; end
        end
        tmo = !(got_a && got_w);
        bv = bus.bvalid; resp = bus.wresp; pulse = wr_pulse_o;
        tick();
        pulse_after = wr_pulse_o; bv_after = bus.bvalid;
    endtask

    task automatic do_read(input logic [4:0] a, output logic rv, output logic [31:0] rd,
                           output logic rv_after, output logic tmo);
        bus.araddr = a; bus.rready = 1'b1; bus.arvalid = 1'b1;
        tmo = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (bus.arready) begin tmo = 1'b0; break; end
            tick();
        end
        tick();
        bus.arvalid = 1'b0;
        rv = bus.rvalid; rd = bus.rdata;
        tick();
        rv_after = bus.rvalid;
    endtask

    initial begin
        logic bv, resp, bva, rv, rva, tmo;
        logic [19:0] pl, pla;
        logic [31:0] rd;

        status = '0;
        status[7] = 32'hA5A5A5A5;
        status[3] = 32'h0BAD0BAD;
        shadow = '0;
        bus.waddr = '0; bus.wdata = '0; bus.wavalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        tbl[0]  = '{1'b0, 5'd3,  32'hDEADBEEF, 1'b0, 20'h00008, 32'h0};
        tbl[1]  = '{1'b1, 5'd3,  32'h0,        1'b0, 20'h0,     32'hDEADBEEF};
        tbl[2]  = '{1'b0, 5'd7,  32'h11111111, 1'b1, 20'h0,     32'h0};
        tbl[3]  = '{1'b1, 5'd7,  32'h0,        1'b0, 20'h0,     32'hA5A5A5A5};
        tbl[4]  = '{1'b0, 5'd25, 32'h55555555, 1'b1, 20'h0,     32'h0};
        tbl[5]  = '{1'b1, 5'd25, 32'h0,        1'b0, 20'h0,     32'h0};
        tbl[6]  = '{1'b0, 5'd19, 32'hCAFEF00D, 1'b0, 20'h80000, 32'h0};
        tbl[7]  = '{1'b1, 5'd19, 32'h0,        1'b0, 20'h0,     32'hCAFEF00D};
        tbl[8]  = '{1'b1, 5'd0,  32'h0,        1'b0, 20'h0,     32'h0};
        tbl[9]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 1'b0, 20'h00001, 32'h0};
        tbl[10] = '{1'b1, 5'd0,  32'h0,        1'b0, 20'h0,     32'hFFFFFFFF};

        tick(); tick();
        chk("rst_readies", {bus.waready, bus.wready, bus.arready}, 3'b000);
        chk("rst_valids", {bus.bvalid, bus.rvalid, bus.wresp}, 3'b000);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_pulse", wr_pulse_o, 20'h0);
        chk_ctrl("rst_ctrl");
        rst_n = 1'b1;
        tick();
        chk("ready_rise", {bus.waready, bus.wready, bus.arready}, 3'b111);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].is_rd) begin
                do_read(tbl[i].addr, rv, rd, rva, tmo);
                chk($sformatf("v%0d_rd_tmo", i), tmo, 1'b0);
                chk($sformatf("v%0d_rvalid", i), rv, 1'b1);
                chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rdata);
                chk($sformatf("v%0d_rvalid_clr", i), rva, 1'b0);
            end else begin
                do_write(tbl[i].addr, tbl[i].data, bv, resp, pl, pla, bva, tmo);
                if (tbl[i].exp_resp == 1'b0) shadow[tbl[i].addr] = tbl[i].data;
                chk($sformatf("v%0d_wr_tmo", i), tmo, 1'b0);
                chk($sformatf("v%0d_bvalid", i), bv, 1'b1);
                chk($sformatf("v%0d_wresp", i), resp, tbl[i].exp_resp);
                chk($sformatf("v%0d_pulse", i), pl, tbl[i].exp_pulse);
                chk($sformatf("v%0d_pulse_clr", i), pla, 20'h0);
                chk($sformatf("v%0d_bvalid_clr", i), bva, 1'b0);
                chk_ctrl($sformatf("v%0d_ctrl", i));
            end
        end

        // Data beat three cycles ahead of the address beat.
        bus.bready = 1'b1;
        bus.wdata = 32'h12345678; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        chk("ooo_wready_drop", {bus.wready, bus.waready, bus.bvalid}, 3'b010);
        tick(); tick();
        chk("ooo_hold", {bus.wready, bus.bvalid}, 2'b00);
        bus.waddr = 5'd5; bus.wavalid = 1'b1;
        tick();
        bus.wavalid = 1'b0;
        shadow[5] = 32'h12345678;
        chk("ooo_bvalid", {bus.bvalid, bus.wresp}, 2'b10);
        chk("ooo_pulse", wr_pulse_o, 20'h00020);
        chk("ooo_slot5", ctrl_view[5], 32'h12345678);
        tick();
        chk("ooo_done", {bus.bvalid, bus.waready, bus.wready}, 3'b011);

        // Write response back-pressure.
        bus.bready = 1'b0;
        bus.waddr = 5'd4; bus.wdata = 32'h00000044; bus.wavalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.wavalid = 1'b0; bus.wvalid = 1'b0;
        shadow[4] = 32'h44;
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("bhold%0d", n), {bus.bvalid, bus.wresp, bus.waready, bus.wready}, 4'b1000);
            tick();
        end
        bus.bready = 1'b1;
        tick();
        chk("bhold_release", {bus.bvalid, bus.waready, bus.wready}, 3'b011);

        // Read data back-pressure.
        bus.rready = 1'b0; bus.araddr = 5'd4; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("rhold%0d", n), {bus.rvalid, bus.arready, bus.rdata}, {2'b10, 32'h44});
            tick();
        end
        bus.rready = 1'b1;
        tick();
        chk("rhold_release", {bus.rvalid, bus.arready}, 2'b01);

        // Same-edge read accept and write commit to slot 2.
        do_write(5'd2, 32'h1, bv, resp, pl, pla, bva, tmo);
        chk("coll_pre_resp", {tmo, bv, resp}, 3'b010);
        bus.waddr = 5'd2; bus.wdata = 32'h2; bus.wavalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 5'd2; bus.arvalid = 1'b1; bus.rready = 1'b1; bus.bready = 1'b1;
        tick();
        bus.wavalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        shadow[2] = 32'h2;
        chk("coll_old", {bus.rvalid, bus.bvalid, bus.rdata}, {2'b11, 32'h1});
        tick();
        do_read(5'd2, rv, rd, rva, tmo);
        chk("coll_new", {tmo, rv, rd}, {2'b01, 32'h2});
        chk_ctrl("coll_ctrl");

        // Reset while a response is pending.
        bus.bready = 1'b0;
        bus.waddr = 5'd8; bus.wdata = 32'h88; bus.wavalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.wavalid = 1'b0; bus.wvalid = 1'b0;
        chk("wresp_pending", bus.bvalid, 1'b1);
        rst_n = 1'b0;
        tick();
        shadow = '0;
        chk("rst_mid_bvalid", {bus.bvalid, bus.waready, bus.wready}, 3'b000);
        chk_ctrl("rst_mid_ctrl");
        rst_n = 1'b1;
        tick();
        chk("rst_mid_ready", {bus.waready, bus.wready, bus.arready, bus.bvalid}, 4'b1110);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
- Responder end of the AXI-lite interface: a word-addressed register bank attached through the interface's slave modport.
- Accepts write address and write data independently, in either order, and returns a one-bit write response.
- Serves reads with one-cycle latency.
- Sits between an AXI-lite master (host/CPU bridge) and core logic. Read-write registers are exported as control outputs; read-only registers are fed by status inputs.

Parameters:
- DEPTH, 32, number of register slots; ADDR_WIDTH = $clog2(DEPTH), word (not byte) addressing.
- DATA_WIDTH, 32, register/data width.
- RO_MASK, {DEPTH{1'b0}}, bit i = 1 makes register i read-only (value from status_i).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- s_axi  interface  axi_lite_if.slave (DEPTH, DATA_WIDTH)  AXI-lite slave channel bundle.
- ctrl_o  output  DEPTH*DATA_WIDTH  flattened RW register contents; slot i at [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o  output  DEPTH  one-cycle strobe, bit i high in the cycle after register i is written.
- status_i  input  DEPTH*DATA_WIDTH  read-only register values, sampled at read accept.

Behaviour:
- Reset (rst_n=0 at an edge):
  - All registers 0; ctrl_o=0; wr_pulse_o=0.
  - waready=wready=arready=0; bvalid=rvalid=0; wresp=0; rdata=0.
  - Both FSMs return to IDLE; any in-flight transaction is dropped without a response.
  - Readies rise to 1 on the first edge with rst_n=1.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: waready high until the address beat is captured; wready high until the data beat is captured. Each is an independent handshake (valid && ready at an edge); after capture, that ready drops and the beat is held.
  - Commit happens on the edge where the second of address/data is captured, or on the single edge if both arrive together.
  - On commit: target register updated; next cycle bvalid=1, wr_pulse_o[addr]=1; FSM enters W_RESP.
  - W_RESP: bvalid, wresp held stable until bvalid && bready. On that edge: bvalid=0, return to W_IDLE, waready=wready=1 next cycle.
  - Write response latency: 1 cycle after commit.
  - wresp encoding: 0 = OKAY, 1 = error.
  - Error writes: address >= DEPTH, or RO_MASK[addr]=1. No register change, no wr_pulse, wresp=1.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On arvalid && arready: rdata registered from the slot (RW register, status_i for RO, 0 if addr >= DEPTH). Next cycle rvalid=1, arready=0.
  - R_DATA: rdata, rvalid held stable until rvalid && rready. On that edge: rvalid=0, arready=1 next cycle.
  - Read latency: 1 cycle.
- Channels are independent: a read and a write may be in flight concurrently.
- Same-edge read accept and write commit to the same address: read returns the pre-write value.
- Read issued the cycle after a commit returns the new value.
- Back-to-back throughput: one write per 2 cycles minimum, one read per 2 cycles minimum.
- ctrl_o is a direct register output with no extra delay. wr_pulse_o is never high for more than one cycle per commit.

Test Plan:
- Reset, then write addr 3 / data 0xDEADBEEF on the same cycle, bready=1 -> bvalid one cycle later with wresp=0; ctrl_o slot 3 = 0xDEADBEEF; wr_pulse_o=0x8 for one cycle; read addr 3 -> rvalid after 1 cycle, rdata=0xDEADBEEF.
- Data beat (0x12345678) 3 cycles before address beat (addr 5) -> wready drops after data capture; commit on the address edge; slot 5 = 0x12345678.
- RO_MASK bit 7 set, status_i slot 7 = 0xA5A5A5A5 -> write addr 7 gives wresp=1 with no pulse; read addr 7 returns 0xA5A5A5A5.
- DEPTH=20, write/read addr 25 -> wresp=1, no state change; rdata=0.
- Hold bready=0 (respectively rready=0) for 4 cycles -> bvalid/wresp (respectively rvalid/rdata) stable throughout; no new address accepted until the handshake completes.
- Same-cycle read accept and write commit to addr 2 (old 0x1, new 0x2) -> rdata=0x1; a following read returns 0x2. Assert rst_n=0 during W_RESP -> bvalid=0 next cycle, registers cleared.
